// File: rtl/fifo_pkg.sv
// Shared types and sizing for the FIFO-to-stream reader.
package fifo_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  localparam int unsigned BUF_DEPTH = 2;
  // Occupancy counter must represent 0..BUF_DEPTH.
  localparam int unsigned OCC_W = 2;
endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer for the reader; head word is presented on o_data.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     i_data,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [W-1:0]     o_data,
  output logic [OCC_W-1:0] o_count
);
  logic [W-1:0]     r_mem [BUF_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [OCC_W-1:0] r_count;

  // Push is never issued when full and pop never when empty; the reader guarantees both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/fifo_reader.sv
// Pops a 1-cycle-latency FIFO and re-presents the words as a valid/ready stream.
module fifo_reader #(
  parameter int MSB   = 3,
  parameter int LSB   = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_read,
  input  logic [MSB:LSB]   fifo_out,
  input  logic             enable = 1'b1,
  output logic [MSB:LSB]   dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             idle,
  output logic [CNT_W-1:0] xfer_cnt
);
  import fifo_pkg::*;

  localparam int W = MSB - LSB + 1;

  rd_state_t        r_state;
  rd_state_t        w_state_nxt;
  logic             r_inflight;
  logic [CNT_W-1:0] r_xfer_cnt;
  logic [OCC_W-1:0] w_count;
  logic [OCC_W:0]   w_committed;
  logic             w_pop;
  logic             w_read;

  fifo_rd_skid #(.W(W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_data  (fifo_out),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .o_data  (dout),
    .o_count (w_count)
  );

  assign dout_valid = (w_count != '0);
  assign w_pop      = dout_valid & dout_ready;

  // Words already owned by the block after this edge: buffered + returning - leaving now.
  assign w_committed = {1'b0, w_count} + {{OCC_W{1'b0}}, r_inflight}
                     - {{OCC_W{1'b0}}, w_pop};
  assign w_read = (r_state == RUN) && enable && !fifo_empty
               && (w_committed < (OCC_W+1)'(BUF_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_inflight <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_read;
      if (w_pop) r_xfer_cnt <= r_xfer_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_nxt = RUN;
      RUN:     if (!enable) w_state_nxt = DRAIN;
      DRAIN: begin
        if (enable)                             w_state_nxt = RUN;
        else if (w_count == '0 && !r_inflight)  w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign fifo_read = w_read;
  assign idle      = (r_state == IDLE) && (w_count == '0) && !r_inflight;
  assign xfer_cnt  = r_xfer_cnt;
endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: source FIFO model plus an in-order word scoreboard.
module tb_fifo_reader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fifo_empty = 1'b1;
  logic        enable = 1'b1;
  logic        dout_ready = 1'b0;
  logic [7:0]  fifo_out = 8'h00;
  logic        fifo_read, dout_valid, idle;
  logic        fifo_read4, dout_valid4, idle4;
  logic [7:0]  dout, dout4;
  logic [15:0] xfer_cnt;
  logic [3:0]  xfer_cnt4;

  always #5 clk = ~clk;

  fifo_reader #(.MSB(7), .LSB(0), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
    .fifo_out(fifo_out), .enable(enable), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .idle(idle), .xfer_cnt(xfer_cnt)
  );

  // Narrow-counter twin fed by the same stimulus, used for the wrap check.
  fifo_reader #(.MSB(7), .LSB(0), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_read(fifo_read4),
    .fifo_out(fifo_out), .enable(enable), .dout(dout4), .dout_valid(dout_valid4),
    .dout_ready(dout_ready), .idle(idle4), .xfer_cnt(xfer_cnt4)
  );

  int nchk = 0, nfail = 0;
  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  bit mon_on = 0, tog_mode = 0, empty_tog = 0, rd_pend = 0, hold_pend = 0;
  logic [7:0] pend_w, hold_d;
  int mcnt, nxfer, nreads, cyc, first_rd, first_vld, first_x, last_x, seq;

  typedef struct {
    int         n;
    int         stall;
    logic [7:0] base;
    int         exp_rd;
  } vec_t;
  vec_t tbl[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Source FIFO: read data appears on the edge after the popping cycle.
  always @(posedge clk) if (rd_pend) fifo_out <= pend_w;

  initial forever begin
    @(posedge clk);
    #2;
    empty_tog  = tog_mode ? ~empty_tog : 1'b0;
    fifo_empty = (src_q.size() == 0) || empty_tog;
  end

  // Inputs are stable from posedge+1, so negedge values are what the next edge sees.
  initial forever begin
    @(negedge clk);
    if (!mon_on) begin
      rd_pend   = 0;
      hold_pend = 0;
    end else begin
      cyc++;
      if (fifo_read) chk("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
      if (hold_pend) begin
        chk("hold_valid", {31'd0, dout_valid}, 32'd1);
        chk("hold_data", {24'd0, dout}, {24'd0, hold_d});
      end
      if (dout_valid && first_vld < 0) first_vld = cyc;
      if (fifo_read && first_rd < 0) first_rd = cyc;
      if (dout_valid && dout_ready) begin
        chk("xfer_cnt", {16'd0, xfer_cnt}, {16'd0, mcnt[15:0]});
        chk("xfer_cnt4", {28'd0, xfer_cnt4}, {28'd0, mcnt[3:0]});
        if (exp_q.size() == 0) begin
          nchk++; nfail++;
          $display("FAIL extra_word: got 0x%0h expected no word", dout);
        end else chk("dout_order", {24'd0, dout}, {24'd0, exp_q.pop_front()});
        if (nxfer == 0) first_x = cyc;
        last_x = cyc;
        mcnt++;
        nxfer++;
      end
      hold_pend = dout_valid && !dout_ready;
      hold_d    = dout;
      rd_pend   = fifo_read && !fifo_empty;
      if (rd_pend) begin
        if (src_q.size() == 0) begin
          nchk++; nfail++; rd_pend = 0;
          $display("FAIL pop_empty_src: got read expected none");
        end else begin
          pend_w = src_q.pop_front();
          exp_q.push_back(pend_w);
          nreads++;
        end
      end
    end
  end

  task automatic do_reset(input int npre, input logic [7:0] base, input bit rdy);
    mon_on = 0; reset = 1'b0; tog_mode = 0; enable = 1'b1; dout_ready = 1'b0;
    src_q.delete(); exp_q.delete();
    tick(); tick();
    for (int i = 0; i < npre; i++) src_q.push_back(base + 8'(i));
    mcnt = 0; nxfer = 0; nreads = 0; cyc = 0;
    first_rd = -1; first_vld = -1; first_x = -1; last_x = -1;
    tick();
    reset = 1'b1; dout_ready = rdy; mon_on = 1;
    @(negedge clk);
    chk("no_read_first_edge", {31'd0, fifo_read}, 32'd0);
    tick();
  endtask

  task automatic wait_n(input int n, input int bound, input string nm);
    int k = 0;
    while (nxfer < n && k < bound) begin
      tick();
      k++;
    end
    chk(nm, nxfer, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    tbl[0] = '{6, 5, 8'h10, 2};
    tbl[1] = '{3, 4, 8'h30, 2};
    tbl[2] = '{1, 3, 8'h50, 1};
    tbl[3] = '{5, 3, 8'h70, 2};

    // Reset values
    tick(); tick();
    chk("rst_fifo_read", {31'd0, fifo_read}, 32'd0);
    chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);

    // Four preloaded words stream back-to-back
    do_reset(4, 8'hA1, 1'b1);
    wait_n(4, 20, "basic_xfers");
    chk("basic_latency", first_vld - first_rd, 2);
    chk("basic_back2back", last_x - first_x, 3);
    chk("basic_cnt", {16'd0, xfer_cnt}, 32'd4);

    // Stalled sink: reads limited to buffer depth, head held, then full drain
    for (int t = 0; t < 4; t++) begin
      do_reset(tbl[t].n, tbl[t].base, 1'b0);
      repeat (tbl[t].stall) tick();
      chk("stall_reads", nreads, tbl[t].exp_rd);
      chk("stall_valid", {31'd0, dout_valid}, 32'd1);
      chk("stall_head", {24'd0, dout}, {24'd0, tbl[t].base});
      dout_ready = 1'b1;
      wait_n(tbl[t].n, 40, "stall_drain");
      chk("stall_cnt", {16'd0, xfer_cnt}, tbl[t].n);
      chk("stall_latency", first_vld - first_rd, 2);
    end

    // Drain: enable drops with two words buffered
    do_reset(8, 8'hC0, 1'b1);
    wait_n(2, 20, "drain_pre");
    dout_ready = 1'b0;
    repeat (4) tick();
    chk("drain_buffered_reads", nreads, 4);
    enable = 1'b0;
    dout_ready = 1'b1;
    k = 0;
    while (!idle && k < 20) begin tick(); k++; end
    chk("drain_idle", {31'd0, idle}, 32'd1);
    chk("drain_no_reads", nreads, 4);
    chk("drain_xfers", nxfer, 4);
    repeat (3) tick();
    chk("idle_no_reads", nreads, 4);
    enable = 1'b1;
    wait_n(8, 30, "resume_xfers");
    chk("resume_empty", exp_q.size(), 0);

    // Counter wrap on the 4-bit twin
    do_reset(17, 8'h00, 1'b1);
    wait_n(16, 40, "wrap16");
    chk("wrap_at16", {28'd0, xfer_cnt4}, 32'd0);
    chk("cnt_at16", {16'd0, xfer_cnt}, 32'd16);
    wait_n(17, 5, "wrap17");
    chk("wrap_at17", {28'd0, xfer_cnt4}, 32'd1);

    // Async reset with one word buffered and one in flight
    do_reset(2, 8'hE1, 1'b0);
    k = 0;
    while (!dout_valid && k < 10) begin tick(); k++; end
    chk("pre_rst_valid", {31'd0, dout_valid}, 32'd1);
    chk("pre_rst_reads", nreads, 2);
    #2;
    mon_on = 0;
    reset = 1'b0;
    #1;
    chk("async_fifo_read", {31'd0, fifo_read}, 32'd0);
    chk("async_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("async_dout", {24'd0, dout}, 32'd0);
    chk("async_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    chk("async_idle", {31'd0, idle}, 32'd1);
    src_q.delete(); exp_q.delete();
    tick(); tick();
    mcnt = 0; nxfer = 0; nreads = 0;
    reset = 1'b1; dout_ready = 1'b1; mon_on = 1;
    repeat (6) tick();
    chk("no_stale_word", nxfer, 0);
    chk("no_stale_valid", {31'd0, dout_valid}, 32'd0);

    // Random: toggling empty flag, random ready and enable
    do_reset(0, 8'h00, 1'b0);
    tog_mode = 1;
    seq = 0;
    for (int c = 0; c < 1000; c++) begin
      if (src_q.size() < 6 && $urandom_range(0, 2) != 0) begin
        src_q.push_back(8'(seq));
        seq++;
      end
      dout_ready = 1'($urandom_range(0, 1));
      enable     = ($urandom_range(0, 15) != 0);
      tick();
    end
    tog_mode = 0; enable = 1'b1; dout_ready = 1'b1;
    k = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && k < 100) begin tick(); k++; end
    chk("rand_drained", src_q.size() + exp_q.size(), 0);
    chk("rand_words", nxfer, seq);
    chk("rand_cnt_out", {16'd0, xfer_cnt}, {16'd0, seq[15:0]});

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameters SHALL be: MSB, default 3, data MSB index; LSB, default 0, data LSB index; CNT_W, default 16, transfer-counter width.
REQ-002 Port clk SHALL be input, 1 bit; the single clock, all state rising-edge.
REQ-003 Port reset SHALL be input, 1 bit; asynchronous, active-low reset.
REQ-004 Port fifo_empty SHALL be input, 1 bit; source FIFO empty flag.
REQ-005 Port fifo_read SHALL be output, 1 bit; source FIFO pop strobe.
REQ-006 Port fifo_out SHALL be input, [MSB:LSB]; FIFO read data, valid exactly 1 cycle after a fifo_read cycle.
REQ-007 Port enable SHALL be input, 1 bit, default value 1'b1 when left unconnected; permits new reads.
REQ-008 Port dout SHALL be output, [MSB:LSB]; stream data.
REQ-009 Port dout_valid SHALL be output, 1 bit; stream valid.
REQ-010 Port dout_ready SHALL be input, 1 bit; stream ready.
REQ-011 Port idle SHALL be output, 1 bit; high when the FSM is in IDLE and nothing is buffered or in flight.
REQ-012 Port xfer_cnt SHALL be output, [CNT_W-1:0]; count of accepted stream words.

Function
REQ-013 A word SHALL transfer on dout when dout_valid and dout_ready are both high on a clock edge.
REQ-014 Once asserted, dout_valid SHALL stay high, with dout stable, until that word transfers.
REQ-015 The output buffer SHALL hold 2 entries and deliver words in FIFO order.
REQ-016 fifo_read SHALL assert only when fifo_empty is low, FSM is RUN, and occupancy plus in-flight words is below 2 after counting a same-cycle dout transfer.
REQ-017 Under these rules the block SHALL never overflow the buffer and never pop an empty FIFO.
REQ-018 The word returned 1 cycle after fifo_read SHALL be captured unconditionally.
REQ-019 With a continuously ready sink and non-empty FIFO, the block SHALL sustain 1 word per cycle.
REQ-020 The first dout_valid SHALL appear 2 cycles after the first fifo_read.
REQ-021 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-022 IDLE->RUN SHALL occur when enable=1.
REQ-023 RUN->DRAIN SHALL occur when enable=0.
REQ-024 In DRAIN the block SHALL issue no new reads while buffered and in-flight words still deliver.
REQ-025 DRAIN->IDLE SHALL occur when the buffer and in-flight count are both zero.
REQ-026 DRAIN->RUN SHALL occur if enable returns high before the drain completes.
REQ-027 xfer_cnt SHALL increment by 1 per transfer and wrap modulo 2^CNT_W with no saturation.
REQ-028 If fifo_empty rises in the same cycle as a pending read decision, no read SHALL be issued.
REQ-029 Simultaneous capture and transfer in one cycle SHALL leave occupancy unchanged.

Reset
REQ-030 On reset low, asynchronously: FSM=IDLE, buffer empty, in-flight cleared, fifo_read=0, dout_valid=0, dout=0, xfer_cnt=0, idle=1.
REQ-031 A word in flight when reset asserts SHALL be discarded.
REQ-032 After reset deasserts, the first fifo_read SHALL occur no earlier than the second rising edge.

Structure
REQ-033 Shared package fifo_pkg SHALL hold the state enum typedef (IDLE, RUN, DRAIN) and the buffer-depth constant (2).
REQ-034 The 2-entry buffer SHALL be a sub-module named fifo_rd_skid, with data, push, pop, count and the same clk/reset.
REQ-035 The FSM, read-issue logic and counter SHALL live in fifo_reader.

Verification
REQ-036 Preload FIFO 8'hA1..8'hA4 (MSB=7), dout_ready=1, enable unconnected -> dout A1,A2,A3,A4 on 4 consecutive cycles; xfer_cnt=4; fifo_read never high while fifo_empty=1.
REQ-037 Preload 6 words, dout_ready low for 5 cycles -> at most 2 fifo_read pulses, dout holds the first word; on ready, all 6 words arrive in order.
REQ-038 Drop enable after 2 transfers with 2 words buffered -> DRAIN, no further fifo_read, 2 more words delivered, then IDLE with idle=1.
REQ-039 CNT_W=4, 17 transfers -> xfer_cnt reads 0 after word 16 and 1 after word 17.
REQ-040 Assert reset with 1 word buffered and 1 in flight -> all outputs take their reset values immediately; no stale word appears after reset deasserts.
REQ-041 Toggle fifo_empty every cycle with random dout_ready for 1000 cycles -> scoreboard shows no loss, duplication or reordering; no read while empty.
